spdif_subframe_decoder: RTL and testbench

- Stage directly downstream of the S/PDIF interval classifier.
- Consumes per-transition interval classes (1, 2 or 3 UI) and recognises the B/M/W preambles.
- Decodes biphase-mark data bits and assembles 32-slot subframes.
- Delivers audio sample, channel, V/U/C bits, parity status and lock indication to the EQ datapath.

---
 rtl/spdif_subframe_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_spdif_subframe_decoder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spdif_subframe_decoder.sv
`default_nettype none
// ============================================================================
// Module   : spdif_subframe_decoder
// Function : Recognises B/M/W preambles in the interval stream, decodes
//            biphase-mark slots and assembles 32-slot subframes with lock.
//            Optional channel-status capture: SPDIF_CS_CAPTURE_EN.
// Revision : 1.0
// ============================================================================
module spdif_subframe_decoder #(
  parameter int SAMPLE_W = 24,
  parameter int LOCK_CNT = 4
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  input  logic                one_i,
  input  logic                two_i,
  input  logic                three_i,
  input  logic                ena_i,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                channel_o,
  output logic                block_start_o,
  output logic                v_o,
  output logic                u_o,
  output logic                c_o,
  output logic                parity_err_o,
  output logic                sample_vld_o,
  output logic                err_o,
  output logic                lock_o
`ifdef SPDIF_CS_CAPTURE_EN
  ,
  output logic [31:0]         cs_o,
  output logic                cs_vld_o
`endif
);

  typedef enum logic [3:0] {
    HUNT, PRE0, PRE1, PRE_B1, PRE_B2, PRE_M1, PRE_M2, PRE_W1, PRE_W2, DATA
  } state_t;

  localparam logic [1:0] c_type_b = 2'd0;
  localparam logic [1:0] c_type_m = 2'd1;
  localparam logic [1:0] c_type_w = 2'd2;
  localparam logic [3:0] c_lock   = 4'(LOCK_CNT);

  state_t      state_q;
  logic [2:0]  cls_q;
  logic [1:0]  type_q;
  logic [4:0]  slot_q;
  logic        half_q;
  // Holds slots 4..30; slot 31 joins combinationally on the final decode.
  logic [26:0] sh_q;
  logic [3:0]  good_q;

  logic        w_c1, w_c2, w_c3, w_cls_ok;
  logic        w_ferr, w_resync;
  logic        w_bit_en, w_done, w_par;
  logic [27:0] w_sh_d;
  logic [3:0]  w_good_d;

  assign w_c1     = (cls_q == 3'b001);
  assign w_c2     = (cls_q == 3'b010);
  assign w_c3     = (cls_q == 3'b100);
  assign w_cls_ok = w_c1 | w_c2 | w_c3;

  assign w_bit_en = ena_i && (state_q == DATA) &&
                    ((w_c2 && !half_q) || (w_c1 && half_q));
  assign w_sh_d   = {w_c1, sh_q};
  assign w_done   = w_bit_en && (slot_q == 5'd31);
  assign w_par    = ^w_sh_d;
  assign w_good_d = (good_q >= c_lock) ? good_q : good_q + 4'd1;

  always_comb begin
    w_ferr   = 1'b0;
    w_resync = 1'b0;
    if (ena_i) begin
      if (!w_cls_ok) begin
        w_ferr = 1'b1;
      end else begin
        case (state_q)
          PRE0:                            w_ferr = !w_c3;
          PRE_B1, PRE_M1, PRE_M2, PRE_W1:  w_ferr = !w_c1;
          PRE_B2:                          w_ferr = !w_c3;
          PRE_W2:                          w_ferr = !w_c2;
          DATA: begin
            if (w_c3) begin
              w_ferr   = 1'b1;
              w_resync = 1'b1;
            end else if (w_c2 && half_q) begin
              w_ferr = 1'b1;
            end
          end
          default: w_ferr = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q       <= HUNT;
      cls_q         <= 3'b000;
      type_q        <= c_type_b;
      slot_q        <= 5'd0;
      half_q        <= 1'b0;
      sh_q          <= 27'd0;
      good_q        <= 4'd0;
      sample_o      <= '0;
      channel_o     <= 1'b0;
      block_start_o <= 1'b0;
      v_o           <= 1'b0;
      u_o           <= 1'b0;
      c_o           <= 1'b0;
      parity_err_o  <= 1'b0;
      sample_vld_o  <= 1'b0;
      err_o         <= 1'b0;
      lock_o        <= 1'b0;
    end else begin
      cls_q        <= {three_i, two_i, one_i};
      sample_vld_o <= 1'b0;
      err_o        <= 1'b0;
      if (ena_i) begin
        if (w_ferr) begin
          err_o   <= 1'b1;
          lock_o  <= 1'b0;
          good_q  <= 4'd0;
          half_q  <= 1'b0;
          state_q <= w_resync ? PRE1 : HUNT;
        end else begin
          case (state_q)
            HUNT:   if (w_c3) state_q <= PRE1;
            PRE0:   state_q <= PRE1;
            PRE1:   state_q <= w_c1 ? PRE_B1 : (w_c3 ? PRE_M1 : PRE_W1);
            PRE_B1: state_q <= PRE_B2;
            PRE_M1: state_q <= PRE_M2;
            PRE_W1: state_q <= PRE_W2;
            PRE_B2, PRE_M2, PRE_W2: begin
              state_q <= DATA;
              slot_q  <= 5'd4;
              half_q  <= 1'b0;
              type_q  <= (state_q == PRE_B2) ? c_type_b :
                         (state_q == PRE_M2) ? c_type_m : c_type_w;
            end
            DATA: begin
              if (w_bit_en) begin
                sh_q   <= w_sh_d[27:1];
                slot_q <= slot_q + 5'd1;
                half_q <= 1'b0;
                if (w_done) begin
                  state_q       <= PRE0;
                  sample_vld_o  <= 1'b1;
                  sample_o      <= w_sh_d[23 -: SAMPLE_W];
                  v_o           <= w_sh_d[24];
                  u_o           <= w_sh_d[25];
                  c_o           <= w_sh_d[26];
                  channel_o     <= (type_q == c_type_w);
                  block_start_o <= (type_q == c_type_b);
                  parity_err_o  <= w_par;
                  if (w_par) begin
                    good_q <= 4'd0;
                    lock_o <= 1'b0;
                  end else begin
                    good_q <= w_good_d;
                    lock_o <= (w_good_d == c_lock);
                  end
                end
              end else begin
                half_q <= 1'b1;
              end
            end
            default: state_q <= HUNT;
          endcase
        end
      end
    end
  end

`ifdef SPDIF_CS_CAPTURE_EN
  logic [31:0] cs_q;
  logic [4:0]  cs_cnt_q;
  logic        cs_act_q;

  assign cs_o = cs_q;

  // Channel-A C bits enter at the MSB so frame 0 lands in bit 0 after 32 frames.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      cs_q     <= 32'd0;
      cs_cnt_q <= 5'd0;
      cs_act_q <= 1'b0;
      cs_vld_o <= 1'b0;
    end else begin
      cs_vld_o <= 1'b0;
      if (ena_i && w_ferr) begin
        cs_act_q <= 1'b0;
      end else if (w_done && (type_q != c_type_w)) begin
        if (type_q == c_type_b) begin
          cs_q     <= {w_sh_d[26], cs_q[31:1]};
          cs_cnt_q <= 5'd1;
          cs_act_q <= 1'b1;
        end else if (cs_act_q) begin
          cs_q     <= {w_sh_d[26], cs_q[31:1]};
          cs_cnt_q <= cs_cnt_q + 5'd1;
          if (cs_cnt_q == 5'd31) begin
            cs_vld_o <= 1'b1;
            cs_act_q <= 1'b0;
          end
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spdif_subframe_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spdif_subframe_decoder
// Function : Scoreboard bench for spdif_subframe_decoder.
// Revision : 1.0
// ============================================================================
module tb_spdif_subframe_decoder;

  localparam int SW = 24;
  localparam int LK = 4;

  logic          clk_i   = 1'b0;
  logic          nrst_i  = 1'b0;
  logic          one_i   = 1'b0;
  logic          two_i   = 1'b0;
  logic          three_i = 1'b0;
  logic          ena_i   = 1'b0;
  logic [SW-1:0] sample_o;
  logic          channel_o, block_start_o, v_o, u_o, c_o;
  logic          parity_err_o, sample_vld_o, err_o, lock_o;
`ifdef SPDIF_CS_CAPTURE_EN
  logic [31:0]   cs_o;
  logic          cs_vld_o;
`endif

  spdif_subframe_decoder #(.SAMPLE_W(SW), .LOCK_CNT(LK)) u_dut (
    .clk_i         (clk_i),
    .nrst_i        (nrst_i),
    .one_i         (one_i),
    .two_i         (two_i),
    .three_i       (three_i),
    .ena_i         (ena_i),
    .sample_o      (sample_o),
    .channel_o     (channel_o),
    .block_start_o (block_start_o),
    .v_o           (v_o),
    .u_o           (u_o),
    .c_o           (c_o),
    .parity_err_o  (parity_err_o),
    .sample_vld_o  (sample_vld_o),
    .err_o         (err_o),
    .lock_o        (lock_o)
`ifdef SPDIF_CS_CAPTURE_EN
    ,
    .cs_o          (cs_o),
    .cs_vld_o      (cs_vld_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [SW-1:0] smp;
    logic ch, bs, v, u, c, perr, lock;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_mon;
  logic [31:0] cs_exp_q[$];
  logic [31:0] cs_word = 32'd0;
  int          cs_idx  = 0;
  bit          cs_act  = 1'b0;
  int          tests   = 0;
  int          fails   = 0;
  int          exp_err = 0;
  int          good    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Slot vector index k holds slot k+4; parity slot makes the 28 slots even unless bad.
  function automatic logic [27:0] mk(input logic [23:0] smp, input logic v, input logic u,
                                     input logic c, input bit bad);
    logic [26:0] d;
    d = {c, u, v, smp};
    return {(^d) ^ bad, d};
  endfunction

  task automatic model_ferr();
    exp_err++;
    good   = 0;
    cs_act = 1'b0;
  endtask

  // typ: 0 = B, 1 = M, 2 = W
  task automatic issue(input int typ, input logic [27:0] s);
    exp_t e;
    e.smp  = s[23 -: SW];
    e.v    = s[24];
    e.u    = s[25];
    e.c    = s[26];
    e.perr = ^s;
    e.ch   = (typ == 2);
    e.bs   = (typ == 0);
    if (e.perr) good = 0;
    else if (good < LK) good++;
    e.lock = (good == LK);
    exp_q.push_back(e);
    if (typ != 2) begin
      if (typ == 0) begin
        cs_act = 1'b1;
        cs_idx = 0;
      end
      if (cs_act) begin
        cs_word[cs_idx] = e.c;
        if (cs_idx == 31) begin
          cs_exp_q.push_back(cs_word);
          cs_act = 1'b0;
        end
        cs_idx++;
      end
    end
  endtask

  task automatic send_cls(input int c);
    one_i   = (c == 1);
    two_i   = (c == 2);
    three_i = (c == 3);
    @(posedge clk_i); #1 ena_i = 1'b1;
    @(posedge clk_i); #1 ena_i = 1'b0;
  endtask

  task automatic send_pre(input int typ);
    case (typ)
      0:       begin send_cls(3); send_cls(1); send_cls(1); send_cls(3); end
      1:       begin send_cls(3); send_cls(3); send_cls(1); send_cls(1); end
      default: begin send_cls(3); send_cls(2); send_cls(1); send_cls(2); end
    endcase
  endtask

  task automatic send_body(input logic [27:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      if (s[i]) begin send_cls(1); send_cls(1); end
      else send_cls(2);
    end
  endtask

  task automatic frame(input int typ, input logic [27:0] s);
    issue(typ, s);
    send_pre(typ);
    send_body(s, 28);
  endtask

  function automatic logic [27:0] rnd_slots(input bit bad);
    return mk(24'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), bad);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk_i) begin
    if (nrst_i) begin
      if (sample_vld_o) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_vld: got sample_vld_o=1 sample %h, required no output", sample_o);
        end else begin
          e_mon = exp_q.pop_front();
          chk("sample",     32'(sample_o),      32'(e_mon.smp));
          chk("channel",    32'(channel_o),     32'(e_mon.ch));
          chk("blk_start",  32'(block_start_o), 32'(e_mon.bs));
          chk("vuc",        32'({v_o, u_o, c_o}), 32'({e_mon.v, e_mon.u, e_mon.c}));
          chk("parity_err", 32'(parity_err_o),  32'(e_mon.perr));
          chk("lock",       32'(lock_o),        32'(e_mon.lock));
        end
      end
      if (err_o) begin
        tests++;
        if (exp_err == 0) begin
          fails++;
          $display("FAIL unexpected_err: got err_o=1, required 0");
        end else begin
          exp_err--;
        end
      end
`ifdef SPDIF_CS_CAPTURE_EN
      if (cs_vld_o) begin
        if (cs_exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_cs_vld: got cs_o %h, required no output", cs_o);
        end else begin
          chk("cs_word", cs_o, cs_exp_q.pop_front());
        end
      end
`endif
    end
  end

  initial begin
    logic [27:0] s;
    int          k;

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_sample", 32'(sample_o), 32'd0);
    chk("rst_flags",  32'({channel_o, block_start_o, v_o, u_o, c_o, parity_err_o}), 32'd0);
    chk("rst_strobe", 32'({sample_vld_o, err_o}), 32'd0);
    chk("rst_lock",   32'(lock_o), 32'd0);
    nrst_i = 1'b1;

    // Block start with known sample, C=1
    frame(0, mk(24'hA5A5A5, 1'b0, 1'b0, 1'b1, 1'b0));
    // Channel B, smallest non-zero sample
    frame(2, mk(24'h000001, 1'b0, 1'b0, 1'b0, 1'b0));

    // Reset in the middle of a subframe discards it
    send_pre(1);
    send_body(rnd_slots(1'b0), 10);
    nrst_i = 1'b0;
    good   = 0;
    cs_act = 1'b0;
    #2;
    chk("midrst_sample", 32'(sample_o), 32'd0);
    chk("midrst_flags",  32'({channel_o, block_start_o, lock_o, sample_vld_o}), 32'd0);
    @(posedge clk_i); #1 nrst_i = 1'b1;

    // Lock rises on the 4th good subframe, then a parity error drops it
    frame(0, rnd_slots(1'b0));
    frame(2, rnd_slots(1'b0));
    frame(1, rnd_slots(1'b0));
    frame(2, rnd_slots(1'b0));
    frame(1, rnd_slots(1'b1));
    frame(2, rnd_slots(1'b0));

    // Interval 2 after a lone 1 mid-data
    send_pre(0);
    send_body(rnd_slots(1'b0), 5);
    send_cls(1);
    model_ferr();
    send_cls(2);
    frame(1, rnd_slots(1'b0));

    // 3 at slot 15 resynchronises straight into a B preamble
    send_pre(1);
    send_body(rnd_slots(1'b0), 11);
    model_ferr();
    send_cls(3);
    s = rnd_slots(1'b0);
    issue(0, s);
    send_cls(1); send_cls(1); send_cls(3);
    send_body(s, 28);

    // 32 stereo frames carrying a channel-status word on channel A
    cs_word = 32'd0;
    for (int f = 0; f < 32; f++) begin
      logic [31:0] cw;
      cw = 32'h0000_8204;
      frame((f == 0) ? 0 : 1, mk(24'($urandom), 1'b0, 1'b0, cw[f], 1'b0));
      frame(2, rnd_slots(1'b0));
    end

    // Randomised traffic with occasional parity and framing faults
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      if (k == 0) begin
        send_pre($urandom_range(0, 2));
        send_body(rnd_slots(1'b0), $urandom_range(0, 27));
        send_cls(1);
        model_ferr();
        send_cls(2);
      end else if (k == 1) begin
        send_pre($urandom_range(0, 2));
        send_body(rnd_slots(1'b0), $urandom_range(0, 27));
        if ($urandom_range(0, 1) == 1) send_cls(1);
        model_ferr();
        send_cls(3);
        s = rnd_slots(1'b0);
        issue(0, s);
        send_cls(1); send_cls(1); send_cls(3);
        send_body(s, 28);
      end else begin
        frame($urandom_range(0, 2), rnd_slots($urandom_range(0, 5) == 0));
      end
    end

    repeat (6) @(posedge clk_i);
    #1;
    chk("vld_pending", 32'(exp_q.size()), 32'd0);
    chk("err_pending", 32'(exp_err), 32'd0);
`ifdef SPDIF_CS_CAPTURE_EN
    chk("cs_pending",  32'(cs_exp_q.size()), 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
